// File: rtl/wb_req_master.sv
// wb_req_master: Wishbone B4 classic initiator.
//
// Turns one core-side valid/ready load/store request into a single Wishbone
// classic cycle and returns the completion on a valid/ready response channel.
// A slave "rty" is reissued after a one-cycle backoff, up to RETRY_LIMIT times;
// after that the request completes with an error. At most one transaction is
// outstanding at any time.
//
// Optional feature: define WB_TIMEOUT_EN to build a watchdog that aborts a bus
// cycle with an error response after TIMEOUT_CYCLES cycles without any
// termination. Without the macro, no counter is built and the bus cycle waits
// indefinitely for termination.
//
// Ports:
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   req_valid_i/ready_o    request handshake; req_adr/dat/sel/we_i request fields
//   rsp_valid_o/ready_i    response handshake; rsp_dat_o read data, rsp_err_o error
//   wbm_*_o                Wishbone master outputs (all registered)
//   wbm_dat/ack/err/rty_i  Wishbone master inputs
//   busy_o                 high whenever a transaction is in progress

module wb_req_master #(
  parameter int unsigned RETRY_LIMIT    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_adr_i,
  input  logic [31:0] req_dat_i,
  input  logic [3:0]  req_sel_i,
  input  logic        req_we_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  output logic        busy_o
);

  // A limit of 0 still needs a 1-bit counter.
  localparam int unsigned RtyW = ($clog2(RETRY_LIMIT + 1) > 0) ? $clog2(RETRY_LIMIT + 1) : 1;
  localparam logic [RtyW-1:0] RtyLimit = RtyW'(RETRY_LIMIT);

  typedef enum logic [1:0] {StIdle, StBus, StBackoff, StResp} state_e;

  state_e          state_q;
  logic [RtyW-1:0] rty_cnt_q;
  logic            tmo_hit;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned TmoW = ($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Expire on the edge that would bring the count to TIMEOUT_CYCLES, so cyc
  // is high for exactly TIMEOUT_CYCLES cycles.
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] tmo_cnt_q;

  assign tmo_hit = (tmo_cnt_q == TmoLast);
`else
  assign tmo_hit = 1'b0;
`endif

  // Ready is gated by reset so nothing is accepted while reset is held.
  assign req_ready_o = (state_q == StIdle) && !wb_rst_i;
  assign busy_o      = (state_q != StIdle);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      rty_cnt_q   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_sel_o   <= '0;
      wbm_we_o    <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
`ifdef WB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            // The wbm_* registers double as the request latches.
            wbm_adr_o <= req_adr_i;
            wbm_dat_o <= req_dat_i;
            wbm_sel_o <= req_sel_i;
            wbm_we_o  <= req_we_i;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            rty_cnt_q <= '0;
`ifdef WB_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
            state_q   <= StBus;
          end
        end

        StBus: begin
          if (wbm_ack_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_dat_o   <= wbm_we_o ? 32'h0 : wbm_dat_i;
            rsp_err_o   <= 1'b0;
            state_q     <= StResp;
          end else if (wbm_err_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b1;
            state_q     <= StResp;
          end else if (wbm_rty_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            if (rty_cnt_q < RtyLimit) begin
              rty_cnt_q <= rty_cnt_q + RtyW'(1);
              state_q   <= StBackoff;
            end else begin
              // Retries exhausted.
              rsp_valid_o <= 1'b1;
              rsp_dat_o   <= '0;
              rsp_err_o   <= 1'b1;
              state_q     <= StResp;
            end
          end else if (tmo_hit) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b1;
            state_q     <= StResp;
          end else begin
`ifdef WB_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
`endif
          end
        end

        StBackoff: begin
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
`ifdef WB_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
          state_q   <= StBus;
        end

        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
            state_q     <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_req_master.sv
// Self-checking bench for wb_req_master: a table of directed transactions,
// randomized transactions checked against a transaction-level model, and
// hand-written sequences for throughput, watchdog/hang and reset mid-bus.

module tb_wb_req_master;

  localparam int unsigned RetryLimit    = 3;
  localparam int unsigned TimeoutCycles = 8;

  // Slave termination kinds for one bus attempt.
  localparam logic [2:0] KAck    = 3'd0;
  localparam logic [2:0] KErr    = 3'd1;
  localparam logic [2:0] KRty    = 3'd2;
  localparam logic [2:0] KAckErr = 3'd3;
  localparam logic [2:0] KNone   = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic [31:0] wadr, wdat_o, wdat_i;
  logic [3:0]  wsel;
  logic        wwe, wcyc, wstb, wack, werr, wrty, busy;

  always #5 clk = ~clk;

  wb_req_master #(
    .RETRY_LIMIT   (RetryLimit),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_adr_i  (req_adr),
    .req_dat_i  (req_dat),
    .req_sel_i  (req_sel),
    .req_we_i   (req_we),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o  (rsp_dat),
    .rsp_err_o  (rsp_err),
    .wbm_adr_o  (wadr),
    .wbm_dat_o  (wdat_o),
    .wbm_sel_o  (wsel),
    .wbm_we_o   (wwe),
    .wbm_cyc_o  (wcyc),
    .wbm_stb_o  (wstb),
    .wbm_dat_i  (wdat_i),
    .wbm_ack_i  (wack),
    .wbm_err_i  (werr),
    .wbm_rty_i  (wrty),
    .busy_o     (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Slave script: attempt a waits sc_wait[a] cycles, then terminates with sc_kind[a].
  int          sc_n;
  logic [2:0]  sc_kind [4];
  int          sc_wait [4];
  logic [31:0] sc_rdata;

  // Transaction-level expectation from the slave script.
  function automatic void model(input logic we, input logic [31:0] rd, output logic err,
                                output logic [31:0] dat, output int cycs, output int gaps);
    int used;
    used = 0; cycs = 0; gaps = 0; err = 1'b1; dat = '0;
    for (int a = 0; a < sc_n; a++) begin
      cycs += sc_wait[a] + 1;
      if (sc_kind[a] == KAck || sc_kind[a] == KAckErr) begin
        err = 1'b0;
        dat = we ? 32'h0 : rd;
        return;
      end
      if (sc_kind[a] == KErr) return;
      if (used == int'(RetryLimit)) return;
      used++;
      gaps++;
    end
  endfunction

  // Starts at a negedge with the DUT idle; ends at a negedge after the response
  // was consumed (or after the cycle budget expired, hung = 1).
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int hold, input int budget,
                         output logic [31:0] r_dat, output logic r_err, output int cycs,
                         output int gaps, output int lat, output int bad, output bit hung);
    int att, in_att;
    att = 0; in_att = 0; cycs = 0; gaps = 0; lat = 0; bad = 0; hung = 1'b1;
    r_dat = '0; r_err = 1'b0;
    chk("req_ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    @(posedge clk);
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      req_valid = 1'b0; wack = 1'b0; werr = 1'b0; wrty = 1'b0;
      req_adr = $urandom; req_dat = $urandom;
      if (rsp_valid) begin
        hung = 1'b0; lat = k; r_dat = rsp_dat; r_err = rsp_err;
        break;
      end
      if (!busy || req_ready) bad++;
      if (wcyc) begin
        cycs++;
        if (!wstb || wadr != adr || wdat_o != dat || wsel != sel || wwe != we) bad++;
        if (att < sc_n && sc_kind[att] != KNone && in_att == sc_wait[att]) begin
          unique case (sc_kind[att])
            KAck:    wack = 1'b1;
            KErr:    werr = 1'b1;
            KAckErr: begin wack = 1'b1; werr = 1'b1; end
            default: wrty = 1'b1;
          endcase
          att++;
          in_att = 0;
        end else begin
          in_att++;
        end
      end else begin
        gaps++;
      end
    end
    if (!hung) begin
      for (int j = 0; j < hold; j++) begin
        @(negedge clk);
        if (!rsp_valid || req_ready || rsp_dat != r_dat || rsp_err != r_err) bad++;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      if (rsp_valid || !req_ready || busy) bad++;
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdata;
    int          n;
    logic [3:0][2:0] kind;
    logic [3:0][3:0] wt;
    logic        exp_err;
    logic [31:0] exp_dat;
    int          exp_cyc;
    int          exp_gaps;
    int          exp_lat;
    int          hold;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
      input logic [3:0] sel, input logic [31:0] rdata, input int n,
      input logic [2:0] k0, input logic [3:0] w0, input logic [2:0] k1, input logic [3:0] w1,
      input logic [2:0] k2, input logic [3:0] w2, input logic [2:0] k3, input logic [3:0] w3,
      input logic exp_err, input logic [31:0] exp_dat, input int exp_cyc, input int exp_gaps,
      input int exp_lat, input int hold);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.rdata = rdata; v.n = n;
    v.kind[0] = k0; v.kind[1] = k1; v.kind[2] = k2; v.kind[3] = k3;
    v.wt[0] = w0; v.wt[1] = w1; v.wt[2] = w2; v.wt[3] = w3;
    v.exp_err = exp_err; v.exp_dat = exp_dat; v.exp_cyc = exp_cyc;
    v.exp_gaps = exp_gaps; v.exp_lat = exp_lat; v.hold = hold;
    return v;
  endfunction

  vec_t        vecs [7];
  logic [31:0] r_dat, m_dat;
  logic        r_err, m_err;
  int          cycs, gaps, lat, bad, m_cyc, m_gaps;
  bit          hung;
  time         t0, t1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    vecs[0] = mk(0, 32'h2000_0100, 32'h0, 4'hF, 32'hDEAD_BEEF, 1, KAck, 0, KNone, 0, KNone, 0,
                 KNone, 0, 1'b0, 32'hDEAD_BEEF, 1, 0, 2, 0);
    vecs[1] = mk(1, 32'h0000_0010, 32'h1234_5678, 4'b0011, 32'hFFFF_0000, 1, KAck, 3, KNone, 0,
                 KNone, 0, KNone, 0, 1'b0, 32'h0, 4, 0, 5, 5);
    vecs[2] = mk(0, 32'h0000_0040, 32'h0, 4'hF, 32'hA5A5_0001, 4, KRty, 0, KRty, 0, KRty, 0,
                 KAck, 0, 1'b0, 32'hA5A5_0001, 4, 3, 8, 0);
    vecs[3] = mk(0, 32'h0000_0044, 32'h0, 4'hF, 32'h1111_1111, 4, KRty, 0, KRty, 1, KRty, 0,
                 KRty, 2, 1'b1, 32'h0, 7, 3, 11, 0);
    vecs[4] = mk(0, 32'h0000_0048, 32'h0, 4'hF, 32'h0BAD_F00D, 1, KAckErr, 1, KNone, 0, KNone, 0,
                 KNone, 0, 1'b0, 32'h0BAD_F00D, 2, 0, 3, 0);
    vecs[5] = mk(1, 32'h0000_004C, 32'hCAFE_F00D, 4'b1000, 32'h2222_2222, 1, KErr, 2, KNone, 0,
                 KNone, 0, KNone, 0, 1'b1, 32'h0, 3, 0, 4, 0);
    vecs[6] = mk(1, 32'h0000_0050, 32'h0102_0304, 4'b0110, 32'h3333_3333, 2, KRty, 1, KAck, 0,
                 KNone, 0, KNone, 0, 1'b0, 32'h0, 3, 1, 5, 0);

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0;
    rsp_ready = 1'b0; wack = 1'b0; werr = 1'b0; wrty = 1'b0; wdat_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_outputs", {23'(0), rsp_valid, rsp_err, wcyc, wstb, wwe, busy, 1'b0, 2'b0}, 32'd0);
    chk("rst_wbm_adr", wadr, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      sc_n = vecs[i].n; sc_rdata = vecs[i].rdata; wdat_i = vecs[i].rdata;
      for (int a = 0; a < 4; a++) begin
        sc_kind[a] = vecs[i].kind[a];
        sc_wait[a] = int'(vecs[i].wt[a]);
      end
      run_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].hold, 60,
              r_dat, r_err, cycs, gaps, lat, bad, hung);
      chk($sformatf("vec%0d_done", i), 32'(hung), 32'd0);
      chk($sformatf("vec%0d_dat", i), r_dat, vecs[i].exp_dat);
      chk($sformatf("vec%0d_err", i), 32'(r_err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_cyc_cycles", i), 32'(cycs), 32'(vecs[i].exp_cyc));
      chk($sformatf("vec%0d_gaps", i), 32'(gaps), 32'(vecs[i].exp_gaps));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_stable", i), 32'(bad), 32'd0);
    end

    // Randomized transactions against the model.
    for (int i = 0; i < 40; i++) begin
      logic        we;
      logic [31:0] adr, dat;
      logic [3:0]  sel;
      we = 1'($urandom); adr = $urandom; dat = $urandom; sel = 4'($urandom);
      sc_rdata = $urandom; wdat_i = sc_rdata;
      sc_n = int'($urandom_range(1, 4));
      for (int a = 0; a < 4; a++) begin
        sc_wait[a] = int'($urandom_range(0, 4));
        if (a < sc_n - 1 || sc_n == 4) sc_kind[a] = 3'($urandom_range(0, 3));
        else sc_kind[a] = 3'($urandom_range(0, 2)) == 3'd2 ? KAckErr : 3'($urandom_range(0, 1));
        if (a < sc_n - 1 && $urandom_range(0, 2) != 0) sc_kind[a] = KRty;
      end
      model(we, sc_rdata, m_err, m_dat, m_cyc, m_gaps);
      run_txn(we, adr, dat, sel, int'($urandom_range(0, 2)), 80,
              r_dat, r_err, cycs, gaps, lat, bad, hung);
      chk($sformatf("rnd%0d_done", i), 32'(hung), 32'd0);
      chk($sformatf("rnd%0d_dat", i), r_dat, m_dat);
      chk($sformatf("rnd%0d_err", i), 32'(r_err), 32'(m_err));
      chk($sformatf("rnd%0d_cyc_cycles", i), 32'(cycs), 32'(m_cyc));
      chk($sformatf("rnd%0d_gaps", i), 32'(gaps), 32'(m_gaps));
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(m_cyc + m_gaps + 1));
      chk($sformatf("rnd%0d_stable", i), 32'(bad), 32'd0);
    end

    // Back-to-back zero-wait reads: one transaction per 3 cycles.
    sc_n = 1; sc_kind[0] = KAck; sc_wait[0] = 0; sc_rdata = 32'h5555_AAAA; wdat_i = sc_rdata;
    t0 = $time;
    run_txn(0, 32'h100, 32'h0, 4'hF, 0, 20, r_dat, r_err, cycs, gaps, lat, bad, hung);
    t1 = $time;
    chk("b2b_spacing", 32'(t1 - t0), 32'd30);
    run_txn(0, 32'h104, 32'h0, 4'hF, 0, 20, r_dat, r_err, cycs, gaps, lat, bad, hung);
    chk("b2b_second_dat", r_dat, 32'h5555_AAAA);

    // Silent slave.
    sc_n = 1; sc_kind[0] = KNone; sc_wait[0] = 0;
`ifdef WB_TIMEOUT_EN
    run_txn(0, 32'h200, 32'h0, 4'hF, 0, 40, r_dat, r_err, cycs, gaps, lat, bad, hung);
    chk("tmo_done", 32'(hung), 32'd0);
    chk("tmo_cyc_cycles", 32'(cycs), 32'(TimeoutCycles));
    chk("tmo_err", 32'(r_err), 32'd1);
    chk("tmo_dat", r_dat, 32'd0);
    chk("tmo_stable", 32'(bad), 32'd0);
`else
    run_txn(0, 32'h200, 32'h0, 4'hF, 0, 1000, r_dat, r_err, cycs, gaps, lat, bad, hung);
    chk("hang_no_response", 32'(hung), 32'd1);
    chk("hang_cyc_cycles", 32'(cycs), 32'd1000);
    chk("hang_stable", 32'(bad), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    // Reset in the middle of a bus cycle, then a late ack.
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h300; req_sel = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrst_cyc_before", 32'(wcyc), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cyc_after", 32'(wcyc), 32'd0);
    chk("midrst_stb_after", 32'(wstb), 32'd0);
    chk("midrst_ready_gated", 32'(req_ready), 32'd0);
    rst = 1'b0; wack = 1'b1; wdat_i = 32'h7777_7777;
    @(negedge clk);
    wack = 1'b0;
    chk("midrst_ready_after", 32'(req_ready), 32'd1);
    chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid || wcyc || busy || !req_ready) bad++;
    end
    chk("midrst_quiet", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_req_master.md
# wb_req_master

Wishbone classic initiator that turns a core-side valid/ready load/store request into one Wishbone B4 classic cycle and returns the completion on a valid/ready response channel. It sits between a CPU load/store unit (or debug port) and the master port of the SoC Wishbone interconnect. It adds bounded retry on `rty` and an optional watchdog timeout, so a missing or hung slave never stalls the core.

## Interface
- `RETRY_LIMIT`, default 3: maximum number of reissues after `wbm_rty_i`; range 0–15.
- `TIMEOUT_CYCLES`, default 255: cycles without termination before the watchdog aborts; range 1–65535; used only with `WB_TIMEOUT_EN`.

Ports (name, direction, width, meaning):
- `wb_clk_i` in 1: single clock. All logic is rising-edge.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when `req_valid_i & req_ready_o`.
- `req_adr_i` in 32: byte address.
- `req_dat_i` in 32: write data.
- `req_sel_i` in 4: byte lane selects.
- `req_we_i` in 1: 1 = write.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response consumed when `rsp_valid_o & rsp_ready_i`.
- `rsp_dat_o` out 32: read data; 0 for writes and for errors.
- `rsp_err_o` out 1: 1 = slave error, retry exhausted, or timeout.
- `wbm_adr_o` out 32, `wbm_dat_o` out 32, `wbm_sel_o` out 4, `wbm_we_o` out 1, `wbm_cyc_o` out 1, `wbm_stb_o` out 1: Wishbone master outputs.
- `wbm_dat_i` in 32, `wbm_ack_i` in 1, `wbm_err_i` in 1, `wbm_rty_i` in 1: Wishbone master inputs.
- `busy_o` out 1: 1 in any state other than IDLE.

## Operation
- **States:** IDLE, BUS, BACKOFF, RESP. Reset forces IDLE.
- **IDLE:**
  - `req_ready_o = 1`.
  - On handshake: latch adr/dat/sel/we, clear the retry and timeout counters, go to BUS.
- **BUS:**
  - `wbm_cyc_o = wbm_stb_o = 1`; address, data, sel and we are driven from the latches and held stable.
  - Termination is sampled on each rising edge while in BUS.
  - Priority when several are high: `ack` > `err` > `rty` > timeout.
  - `ack`: capture `wbm_dat_i` if read (0 if write), `rsp_err_o = 0`, go to RESP.
  - `err`: `rsp_dat_o = 0`, `rsp_err_o = 1`, go to RESP.
  - `rty` with retry count < `RETRY_LIMIT`: increment the count, go to BACKOFF.
  - `rty` with retry count = `RETRY_LIMIT`: error response, go to RESP.
- **BACKOFF:** exactly one cycle with `cyc`/`stb` = 0; the timeout counter is cleared; return to BUS with the same latched fields.
- **RESP:** `rsp_valid_o = 1` with data and err held stable until `rsp_ready_i`, then go to IDLE. No new request is accepted until RESP completes, so at most one transaction is outstanding.
- **Retry counter:** `$clog2(RETRY_LIMIT+1)` bits, minimum 1; never wraps.
- **Reset mid-transaction:**
  - `cyc`/`stb` drop in the cycle after the reset edge.
  - The latched request is discarded and no response is produced.
  - A late `ack` arriving in IDLE is ignored.
- **Reset values:** every output is 0, except `req_ready_o`, which is 1 in the first cycle after reset is released (it is gated low while `wb_rst_i` = 1).

## Timing
- **Accept to bus:** request handshake at edge N → `cyc`/`stb` high from cycle N+1 (registered outputs).
- **Bus to response:** `ack` sampled at edge M → `cyc`/`stb` low and `rsp_valid_o` high in cycle M+1. Minimum request-to-response latency is 2 cycles with a zero-wait-state slave.
- **Back-to-back throughput:** one transaction per 3 cycles with an immediately-ready response consumer. RESP → IDLE costs 1 cycle; no response/request bypass.
- **Retry spacing:** `rty` at edge M → BACKOFF in cycle M+1 (cyc = 0) → reissue in cycle M+2.
- **Outputs:** `wbm_*` outputs are registered; `req_ready_o` and `busy_o` are decoded from the state register.

## Configuration
- **`WB_TIMEOUT_EN` defined:**
  - A counter of `$clog2(TIMEOUT_CYCLES+1)` bits increments each BUS cycle without termination.
  - When it reaches `TIMEOUT_CYCLES`: `cyc`/`stb` drop next cycle, `rsp_err_o = 1`, `rsp_dat_o = 0`, go to RESP.
  - `ack`/`err`/`rty` on the expiry edge take priority over the timeout.
- **`WB_TIMEOUT_EN` undefined:** no counter is built; BUS waits indefinitely for termination.

## Test plan
- **Zero-wait read:** read of 0x20000100, slave acks in the first BUS cycle with 0xDEADBEEF → `rsp_valid_o` 2 cycles after the request handshake, `rsp_dat_o` = 0xDEADBEEF, `rsp_err_o` = 0.
- **Write with stall:** write 0x12345678, sel 4'b0011, to 0x00000010; slave acks after 3 wait cycles → `cyc` high for 4 cycles with stable adr/dat/sel/we = 1; response `rsp_dat_o` = 0, err = 0. Holding `rsp_ready_i` = 0 for 5 cycles keeps `rsp_valid_o` high and `req_ready_o` low.
- **Retry:** slave returns `rty` 3 times, then `ack` (`RETRY_LIMIT` = 3) → three 1-cycle cyc-low gaps, then a successful response. With `rty` 4 times → `rsp_err_o` = 1.
- **Simultaneous termination:** `ack` and `err` high in the same cycle → ack wins, `rsp_err_o` = 0.
- **Timeout:** with `WB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8, the slave never responds → `cyc` high exactly 8 cycles, then `rsp_err_o` = 1, `rsp_dat_o` = 0. Without the macro, `cyc` stays high for 1000 cycles.
- **Reset mid-BUS:** assert `wb_rst_i` during BUS, then send a late `ack` → `cyc` = 0 the cycle after reset, no `rsp_valid_o`, `req_ready_o` = 1 after release.
